// File: rtl/decode_38_seq.sv
// decode_38_seq
// -----------------------------------------------------------------------------
// Purpose:
//   Sequenced 3-to-8 decoder. An accepted 3-bit code is turned into a registered
//   one-hot word that stays on 'out' for hold_len+1 cycles. While a word is
//   being held, one further code can wait in a single-entry pending buffer.
//   When the current word expires, the next word follows on the very next
//   cycle with no gap. That word is the pending code if one is waiting,
//   otherwise a code accepted on the expiry cycle itself (bypass).
//
// Parameters:
//   HOLD_W     width of hold_len and of the internal hold counter (default 4)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   accept enable; 0 blocks new codes but lets held work drain
//   in_code    in   [2:0] code to decode
//   in_valid   in   in_code is valid
//   in_ready   out  a code can be accepted this cycle
//   hold_len   in   [HOLD_W-1:0] extra cycles each word is held, sampled at load
//   out        out  [7:0] registered one-hot decode (or all-zero)
//   out_valid  out  out carries a live decoded word
//   pend_full  out  pending buffer occupied
//
// Build option:
//   DECODE_38_STICKY_EN  when defined, 'out' keeps its last one-hot value on
//                        the return to IDLE (out_valid still drops). When it is
//                        undefined, 'out' is cleared to zero on that edge.
// -----------------------------------------------------------------------------
module decode_38_seq #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        in_code,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HOLD_W-1:0] hold_len,
    output logic [7:0]        out,
    output logic              out_valid,
    output logic              pend_full
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [7:0]        out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              pend_full_q, pend_full_d;
    logic [2:0]        pend_code_q, pend_code_d;

    logic [7:0]        in_onehot;
    logic [7:0]        pend_onehot;
    logic              accept;

    // One-hot decode of both candidate sources. Each bit compares against its
    // own index, so at most one bit can ever be set.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign in_onehot[gi]   = (in_code == 3'(gi));
            assign pend_onehot[gi] = (pend_code_q == 3'(gi));
        end
    endgenerate

    // In IDLE the pending buffer is always empty. During HOLD the single
    // pending slot is the only place to put a new code.
    assign in_ready = en & ((state_q == IDLE) | ~pend_full_q);
    assign accept   = en & in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_code_d = pend_code_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_d       = in_onehot;
                    out_valid_d = 1'b1;
                    cnt_d       = hold_len;
                    state_d     = HOLD;
                end
            end

            HOLD: begin
                if (cnt_q != '0) begin
                    // Word still has cycles left; a new code can only park.
                    cnt_d = cnt_q - CNT_ONE;
                    if (accept) begin
                        pend_code_d = in_code;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    // Last cycle of the current word: the parked code takes
                    // over next cycle. in_ready is low here, so no accept races it.
                    out_d       = pend_onehot;
                    cnt_d       = hold_len;
                    pend_full_d = 1'b0;
                end else if (accept) begin
                    // Last cycle, nothing parked. The fresh code goes straight to out.
                    out_d = in_onehot;
                    cnt_d = hold_len;
                end else begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
`ifdef DECODE_38_STICKY_EN
                    out_d       = out_q;
`else
                    out_d       = 8'h00;
`endif
                end
            end

            default: begin
                state_d     = IDLE;
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                cnt_d       = '0;
                pend_full_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_code_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_code_q <= pend_code_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign pend_full = pend_full_q;

endmodule

// File: tb/tb_decode_38_seq.sv
// tb_decode_38_seq
// -----------------------------------------------------------------------------
// Scoreboard bench for decode_38_seq. The stimulus process drives one cycle at
// a time and advances a word-level reference model. That model keeps a queue
// of accepted codes: the head is on display and at most one code waits behind
// it. Each word gets hold_len+1 display cycles, fixed when it reaches the head.
// The expected outputs after each edge are pushed with a target cycle stamp.
// A monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_decode_38_seq;

    localparam int HOLD_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2:0]        in_code;
    logic              in_valid;
    logic              in_ready;
    logic [HOLD_W-1:0] hold_len;
    logic [7:0]        out;
    logic              out_valid;
    logic              pend_full;

    decode_38_seq #(.HOLD_W(HOLD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hold_len  (hold_len),
        .out       (out),
        .out_valid (out_valid),
        .pend_full (pend_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tgt;
        logic [7:0] o;
        logic       v;
        logic       p;
    } exp_t;

    exp_t sb[$];

    // Reference model state.
    int         m_codes[$];   // head = displayed word, [1] = waiting word
    int         m_left = 0;   // display cycles left for the head word
    logic [7:0] m_last = 8'h00;
    bit         m_acc;

    task automatic model_reset();
        m_codes.delete();
        m_left = 0;
        m_last = 8'h00;
    endtask

    // One clock cycle. Called at posedge+1 and returns at the next posedge+1.
    task automatic step(input bit e, input bit v, input int c, input int hl);
        bit   m_ready;
        exp_t x;
        en       = e;
        in_valid = v;
        in_code  = 3'(c);
        hold_len = HOLD_W'(hl);

        m_ready = e && (m_codes.size() < 2);
        m_acc   = e && v && m_ready;

        // What the coming edge does to the word schedule.
        if (m_codes.size() > 0) begin
            m_left--;
            if (m_left == 0) begin
                void'(m_codes.pop_front());
                if (m_codes.size() > 0) m_left = hl + 1;
            end
        end
        if (m_acc) begin
            m_codes.push_back(c);
            if (m_codes.size() == 1) m_left = hl + 1;
        end

        x.tgt = cyc + 1;
        if (m_codes.size() > 0) begin
            x.o    = 8'(1 << m_codes[0]);
            x.v    = 1'b1;
            x.p    = (m_codes.size() == 2);
            m_last = x.o;
        end else begin
            x.v = 1'b0;
            x.p = 1'b0;
`ifdef DECODE_38_STICKY_EN
            x.o = m_last;
`else
            x.o = 8'h00;
`endif
        end
        sb.push_back(x);

        #1;
        total++;
        if (in_ready !== m_ready) begin
            bad++;
            $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, m_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT outputs against the scoreboard entry due this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ($countones(out) > 1) begin
                bad++;
                $display("FAIL onehot cyc=%0d got=%h want=at most one bit", cyc, out);
            end
        end
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            total++;
            if (x.tgt < cyc) begin
                bad++;
                $display("FAIL stale_entry cyc=%0d got=unchecked want=tgt %0d", cyc, x.tgt);
            end else if (out !== x.o || out_valid !== x.v || pend_full !== x.p) begin
                bad++;
                $display("FAIL outputs cyc=%0d got out=%h v=%b p=%b want out=%h v=%b p=%b",
                         cyc, out, out_valid, pend_full, x.o, x.v, x.p);
            end else begin
                $display("cyc=%0d out=%h v=%b p=%b ok", cyc, out, out_valid, pend_full);
            end
        end
    end

    task automatic idle(input int n, input int hl);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, hl);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
        hold_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out !== 8'h00 || out_valid !== 1'b0 || pend_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got out=%h v=%b p=%b want out=00 v=0 p=0",
                     out, out_valid, pend_full);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, hold_len=2, code 5.
        step(1'b1, 1'b1, 5, 2);
        idle(5, 2);

        // Back-to-back with a pending code, hold_len=1.
        step(1'b1, 1'b1, 3, 1);
        step(1'b1, 1'b1, 6, 1);
        idle(6, 1);

        // Backpressure, hold_len=7: 1, 2, then 4 held until it is taken.
        step(1'b1, 1'b1, 1, 7);
        step(1'b1, 1'b1, 2, 7);
        begin
            int n;
            n = 0;
            do begin
                step(1'b1, 1'b1, 4, 7);
                n++;
            end while (!m_acc && n < 40);
            total++;
            if (!m_acc) begin
                bad++;
                $display("FAIL backpressure_accept got=not accepted want=accepted within 40");
            end
        end
        idle(20, 7);

        // Bypass walk with hold_len=0, then en dropped mid-sequence.
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, c, 0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, c, 0);
        for (int c = 4; c < 8; c++) step(1'b0, 1'b1, c, 0);
        idle(3, 0);

        // hold_len changes mid-hold, with en low while draining.
        step(1'b1, 1'b1, 2, 4);
        step(1'b1, 1'b1, 7, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, i);
        idle(4, 0);

        // Asynchronous reset in the middle of a hold with a pending code.
        step(1'b1, 1'b1, 7, 5);
        step(1'b1, 1'b1, 1, 5);
        step(1'b1, 1'b0, 0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out !== 8'h00 || out_valid !== 1'b0 || pend_full !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got out=%h v=%b p=%b want out=00 v=0 p=0",
                     out, out_valid, pend_full);
        end
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit e;
            bit v;
            int hl;
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 2) != 0);
            hl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 3));
            step(e, v, int'($urandom_range(0, 7)), hl);
        end
        idle(40, 0);

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d entries want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
